// File: rtl/lte_scr_pkg.sv
// ----------------------------------------------------------------------------
// Module   : lte_scr_pkg
// Purpose  : Shared types and constants for the LTE PDSCH bit scrambler.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package lte_scr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [30:0] X1_SEED    = 31'h0000_0001;
    localparam int          NC_DEFAULT = 1600;

    // Feedback taps as masks: x1 uses n and n+3, x2 uses n..n+3.
    localparam logic [30:0] X1_TAPS = 31'h0000_0009;
    localparam logic [30:0] X2_TAPS = 31'h0000_000F;

endpackage

`default_nettype wire

// File: rtl/lte_scrambler_gold.sv
// ----------------------------------------------------------------------------
// Module   : gold_lfsr
// Purpose  : Pair of 31-bit LFSRs producing the length-31 Gold sequence c(n).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gold_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [30:0] seed_x2,
    input  logic        adv,
    output logic        c
);
    import lte_scr_pkg::*;

    logic [30:0] r_x1;
    logic [30:0] r_x2;

    // Right shift; the XOR of the tapped bits enters at position 30.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1 <= '0;
            r_x2 <= '0;
        end else if (load) begin
            r_x1 <= X1_SEED;
            r_x2 <= seed_x2;
        end else if (adv) begin
            r_x1 <= {^(r_x1 & X1_TAPS), r_x1[30:1]};
            r_x2 <= {^(r_x2 & X2_TAPS), r_x2[30:1]};
        end
    end

    assign c = r_x1[0] ^ r_x2[0];

endmodule

`default_nettype wire

// File: rtl/lte_scrambler.sv
// ----------------------------------------------------------------------------
// Module   : lte_scrambler
// Purpose  : Serial LTE PDSCH scrambler, f_k = e_k ^ c(n) over one codeword.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lte_scrambler
    import lte_scr_pkg::*;
#(
    parameter int NC  = NC_DEFAULT,
    parameter int G_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [30:0]    c_init,
    input  logic [G_W-1:0] G,
    input  logic           e_k,
    input  logic           e_valid,
    output logic           in_ready,
    output logic           f_k,
    output logic           f_valid,
    output logic           busy,
    output logic           done
);

    localparam int c_warm_w = (NC > 0) ? $clog2(NC + 1) : 1;
    localparam logic [c_warm_w-1:0] c_warm_last = (NC > 0) ? c_warm_w'(NC - 1) : '0;

    state_t              r_state;
    state_t              w_next_state;
    logic [G_W-1:0]      r_g;
    logic [G_W-1:0]      r_bit_cnt;
    logic [c_warm_w-1:0] r_warm_cnt;
    logic                r_in_ready;
    logic                r_f_k;
    logic                r_f_valid;
    logic                r_busy;
    logic                r_done;
    logic                w_load;
    logic                w_adv;
    logic                w_accept;
    logic                w_last;
    logic                w_c;

    gold_lfsr u_gold (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .seed_x2 (c_init),
        .adv     (w_adv),
        .c       (w_c)
    );

    // r_in_ready is only ever set while in RUN, so it doubles as the RUN qualifier.
    assign w_accept = e_valid && r_in_ready;
    assign w_last   = w_accept && (r_bit_cnt == (r_g - G_W'(1)));

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_load = 1'b1;
                    if (G == '0)
                        w_next_state = DONE;
                    else if (NC == 0)
                        w_next_state = RUN;
                    else
                        w_next_state = WARM;
                end
            end
            WARM: begin
                w_adv = 1'b1;
                if (r_warm_cnt == c_warm_last)
                    w_next_state = RUN;
            end
            RUN: begin
                w_adv = w_accept;
                if (w_last)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_bit_cnt  <= '0;
            r_warm_cnt <= '0;
            r_in_ready <= 1'b0;
            r_f_k      <= 1'b0;
            r_f_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == RUN);
            r_busy     <= (w_next_state != IDLE);
            r_done     <= (w_next_state == DONE);
            r_f_valid  <= w_accept;
            if (w_accept)
                r_f_k <= e_k ^ w_c;
            if (w_load) begin
                r_g        <= G;
                r_bit_cnt  <= '0;
                r_warm_cnt <= '0;
            end else begin
                if (r_state == WARM)
                    r_warm_cnt <= r_warm_cnt + 1'b1;
                if (w_accept)
                    r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign f_k      = r_f_k;
    assign f_valid  = r_f_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lte_scrambler.sv
// ----------------------------------------------------------------------------
// Module   : tb_lte_scrambler
// Purpose  : Self-checking bench for lte_scrambler with NC=0 and NC=1600 copies.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lte_scrambler;

    localparam int G_W = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           e_k = 1'b0;
    logic           e_valid = 1'b0;
    logic [30:0]    c_init = '0;
    logic [G_W-1:0] G = '0;

    logic f_k0, f_valid0, in_ready0, busy0, done0;
    logic f_k1, f_valid1, in_ready1, busy1, done1;

    always #5 clk = ~clk;

    lte_scrambler #(.NC(0), .G_W(G_W)) dut0 (
        .clk(clk), .rst(rst), .en(en), .c_init(c_init), .G(G),
        .e_k(e_k), .e_valid(e_valid), .in_ready(in_ready0),
        .f_k(f_k0), .f_valid(f_valid0), .busy(busy0), .done(done0)
    );

    lte_scrambler #(.NC(1600), .G_W(G_W)) dut1 (
        .clk(clk), .rst(rst), .en(en), .c_init(c_init), .G(G),
        .e_k(e_k), .e_valid(e_valid), .in_ready(in_ready1),
        .f_k(f_k1), .f_valid(f_valid1), .busy(busy1), .done(done1)
    );

    int n_err = 0;
    int n_chk = 0;
    int sel_mon = 0;
    int n_done = 0;
    int n_done_fv = 0;
    bit q_out[$];
    bit e_in[$];
    bit c_ref[$];

    logic m_fv, m_fk, m_done;
    assign m_fv   = (sel_mon != 0) ? f_valid1 : f_valid0;
    assign m_fk   = (sel_mon != 0) ? f_k1     : f_k0;
    assign m_done = (sel_mon != 0) ? done1    : done0;

    always @(negedge clk) begin
        if (m_fv)
            q_out.push_back(m_fk);
        if (m_done) begin
            n_done++;
            if (m_fv)
                n_done_fv++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Gold sequence straight from the recurrences: c(n) = x1(n+NC) ^ x2(n+NC).
    task automatic build_ref(input logic [30:0] ci, input int nc, input int len);
        int total;
        bit x1[];
        bit x2[];
        total = nc + len + 31;
        x1 = new[total];
        x2 = new[total];
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int n = 0; n + 31 < total; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        c_ref.delete();
        for (int i = 0; i < len; i++)
            c_ref.push_back(x1[nc+i] ^ x2[nc+i]);
    endtask

    task automatic start_cw(input logic [30:0] ci, input int g);
        q_out.delete();
        e_in.delete();
        n_done    = 0;
        n_done_fv = 0;
        c_init = ci;
        G      = G_W'(g);
        en     = 1'b1;
        @(posedge clk); #1;
        en     = 1'b0;
    endtask

    task automatic feed(input int sel, input int n, input bit gaps, input bit zeros,
                        input int en_at, output int low_cycles);
        int  acc;
        int  cyc;
        bit  seen;
        logic rdy;
        acc = 0; cyc = 0; seen = 0; low_cycles = 0;
        while (acc < n && cyc < 5000) begin
            e_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            e_k     = zeros ? 1'b0 : 1'($urandom_range(0, 1));
            en      = (en_at >= 0) && (acc == en_at);
            @(negedge clk);
            rdy = (sel != 0) ? in_ready1 : in_ready0;
            if (!rdy && !seen)
                low_cycles++;
            if (rdy)
                seen = 1;
            if (rdy && e_valid) begin
                e_in.push_back(e_k);
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        e_valid = 1'b0;
        en      = 1'b0;
        check("feed_accepted", acc, n);
    endtask

    task automatic finish_cw(input string tag, input int sel, input logic [30:0] ci,
                             input int nc, input int g);
        int mism;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check({tag, "_count"}, q_out.size(), g);
        check({tag, "_done"}, n_done, 1);
        check({tag, "_done_with_last"}, n_done_fv, 1);
        build_ref(ci, nc, g);
        mism = 0;
        for (int i = 0; i < g; i++)
            if (i >= q_out.size() || q_out[i] !== (e_in[i] ^ c_ref[i]))
                mism++;
        check({tag, "_data_mismatches"}, mism, 0);
        check({tag, "_busy_after"}, (sel != 0) ? busy1 : busy0, 1'b0);
    endtask

    initial begin
        int low;
        logic [31:0] v;
        logic [30:0] ci;

        repeat (3) @(posedge clk); #1;
        check("reset_outputs_nc0",    {27'b0, f_k0, f_valid0, in_ready0, busy0, done0}, 32'h0);
        check("reset_outputs_nc1600", {27'b0, f_k1, f_valid1, in_ready1, busy1, done1}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // NC=0, c_init=0, zeros in: raw sequence 1, 30 zeros, 1
        sel_mon = 0;
        start_cw(31'h0, 32);
        feed(0, 32, 1'b0, 1'b1, -1, low);
        check("nc0_ready_low", low, 0);
        finish_cw("nc0_seed0", 0, 31'h0, 0, 32);
        v = '0;
        for (int i = 0; i < 32 && i < q_out.size(); i++) v[i] = q_out[i];
        check("nc0_seed0_pattern", v, 32'h8000_0001);

        // NC=0, c_init=1: x1 and x2 cancel for the first 32 bits
        start_cw(31'h1, 32);
        feed(0, 32, 1'b0, 1'b1, -1, low);
        finish_cw("nc0_seed1", 0, 31'h1, 0, 32);
        v = 32'hFFFF_FFFF;
        for (int i = 0; i < 32 && i < q_out.size(); i++) v[i] = q_out[i];
        check("nc0_seed1_pattern", v, 32'h0);

        // NC=0, random seed and data with gaps
        ci = 31'($urandom);
        start_cw(ci, 100);
        feed(0, 100, 1'b1, 1'b0, -1, low);
        finish_cw("nc0_random", 0, ci, 0, 100);

        // G=0: straight to DONE, no output bits
        start_cw(31'h5, 0);
        @(negedge clk);
        check("g0_busy_done_state", busy0, 1'b1);
        check("g0_done_pulse", done0, 1'b1);
        check("g0_no_fvalid", f_valid0, 1'b0);
        @(negedge clk);
        check("g0_busy_cleared", busy0, 1'b0);
        check("g0_done_cleared", done0, 1'b0);
        check("g0_done_count", n_done, 1);
        check("g0_no_output_bits", q_out.size(), 0);
        @(posedge clk); #1;

        // NC=1600: warm-up with dropped e_valid bits, en re-asserted mid-RUN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sel_mon = 1;
        ci = 31'($urandom);
        start_cw(ci, 1000);
        feed(1, 1000, 1'b1, 1'b0, 300, low);
        check("nc1600_ready_low_cycles", low, 1600);
        finish_cw("nc1600_random", 1, ci, 1600, 1000);

        // Asynchronous reset at bit 500, then a clean restart
        start_cw(31'($urandom), 1000);
        feed(1, 500, 1'b1, 1'b0, -1, low);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {27'b0, f_k1, f_valid1, in_ready1, busy1, done1}, 32'h0);
        check("midrun_reset_no_done", n_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_cw(31'h1234, 64);
        feed(1, 64, 1'b1, 1'b0, -1, low);
        check("restart_ready_low_cycles", low, 1600);
        finish_cw("restart_1234", 1, 31'h1234, 1600, 64);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
